program_counter: RTL and testbench
==================================

// Module: program_counter
// PURPOSE
//   Program counter stage directly downstream of the instruction decoder. Consumes
//   the decoder's pcInc/pcBranchAbs/pcBranchRel controls and registers the address
//   of the next instruction fed to program memory. Tracks hold (WAIT) loops and
//   reports branch events; an optional return-address stack supports call/return.
// PARAMETERS
//   PC_WIDTH     6   program counter / program memory address width (bits)
//   OFF_WIDTH    6   signed relative-branch offset width (bits), <= PC_WIDTH
//   HOLD_WIDTH   8   width of the saturating hold-cycle counter
//   STACK_DEPTH  4   return stack entries (used only with PC_RETURN_STACK_EN)
// PORTS
//   clk           in   1           system clock, all state on rising edge
//   reset         in   1           synchronous, active-high reset
//   pcInc         in   1           from decoder: advance PC by 1
//   pcBranchAbs   in   1           from decoder: load branchAddr
//   pcBranchRel   in   1           from decoder: add branchOffset to PC
//   branchAddr    in   PC_WIDTH    absolute target (immediate field)
//   branchOffset  in   OFF_WIDTH   signed two's-complement relative offset
//   pcCall        in   1           call: push PC+1, jump to branchAddr
//   pcReturn      in   1           return: pop stack into PC
//   stall         in   1           freeze PC and stack this cycle
//   pcOut         out  PC_WIDTH    current PC, drives program memory address
//   branchTaken   out  1           registered pulse: last update was non-sequential
//   holding       out  1           PC unchanged on >=1 consecutive cycle (WAIT loop)
//   holdCount     out  HOLD_WIDTH  consecutive held cycles, saturating at all-ones
//   stackErr      out  1           sticky: stack overflow or underflow occurred
// BEHAVIOUR
//   - Reset (sync, high): pcOut=0, branchTaken=0, holding=0, holdCount=0,
//     stackErr=0, stack pointer=0 (empty). Reset mid-WAIT/mid-call discards all.
//   - Next-PC priority each cycle: reset > stall > pcReturn > pcCall >
//     pcBranchAbs > pcBranchRel > pcInc > hold (PC unchanged).
//   - Latency: controls sampled at edge N, new pcOut visible after edge N; no
//     combinational path from inputs to any output.
//   - pcInc: PC+1 modulo 2^PC_WIDTH (all-ones wraps to 0, no flag).
//   - pcBranchRel: PC + sign-extended branchOffset, modulo 2^PC_WIDTH; offset 0
//     is a legal self-loop and counts as a hold.
//   - pcBranchAbs and pcBranchRel both high: absolute wins (decoder never does it).
//   - branchTaken=1 for one cycle after any update from pcReturn, pcCall,
//     pcBranchAbs or pcBranchRel (incl. offset 0); 0 after inc, hold or stall.
//   - Hold tracking: if next PC == current PC and not stall, holdCount increments
//     (saturates, never wraps) and holding=1; any PC change clears both to 0.
//     Stall freezes holdCount and holding at their current values.
//   - stall high: PC, stack, holdCount, holding frozen; branchTaken forced to 0.
// CONFIGURATION
//   PC_RETURN_STACK_EN defined:
//     - STACK_DEPTH x PC_WIDTH LIFO. pcCall pushes PC+1 (wrapped), PC<=branchAddr.
//     - pcReturn pops top into PC. pcCall+pcReturn same cycle: return wins, no push.
//     - Push when full: PC<=branchAddr, push dropped, stackErr<=1.
//     - Pop when empty: PC<=PC+1, stackErr<=1. stackErr cleared only by reset.
//   PC_RETURN_STACK_EN undefined:
//     - No stack storage. pcCall behaves exactly as pcBranchAbs; pcReturn
//       behaves exactly as pcInc. stackErr tied 0. Port list identical.
// TESTING
//   1. reset 2 cycles, pcInc=1 for 70 cycles -> pcOut 0..63 then 0,1,...;
//      branchTaken always 0, holding always 0.
//   2. PC=10, pcBranchRel, branchOffset=-3 -> pcOut=7, branchTaken=1 one cycle;
//      PC=62, offset=+5 -> pcOut=3.
//   3. PC=20, all controls 0 (WAIT) for 300 cycles -> holding=1 from cycle 1,
//      holdCount 1..255 then stays 255; pcInc -> pcOut=21, holdCount=0, holding=0.
//   4. pcBranchAbs+pcBranchRel, addr=40, offset=+1, PC=5 -> pcOut=40; stall=1
//      with pcInc -> pcOut stays 40, branchTaken=0.
//   5. (EN) PC=3 call 30, PC=31 call 50, return -> pcOut=32, return -> pcOut=4;
//      5 nested calls at depth 4 -> stackErr=1; return on empty -> PC+1.
//   6. (no EN) pcCall addr=12 -> pcOut=12, branchTaken=1; pcReturn -> pcOut=13,
//      stackErr=0. Reset asserted mid-sequence -> all outputs 0 next cycle.

Source files
------------

// File: rtl/program_counter.sv
//-----------------------------------------------------------------------------
// program_counter
//   Program counter stage fed by the instruction decoder. Selects the next
//   instruction address from the decoder controls and registers it for
//   program memory. Tracks WAIT (hold) loops with a saturating counter and
//   flags branch-type updates with a one-cycle pulse.
//
//   Optional feature: define PC_RETURN_STACK_EN to build a STACK_DEPTH-entry
//   return-address LIFO for pcCall/pcReturn. Without it, pcCall acts as
//   pcBranchAbs, pcReturn acts as pcInc and stackErr is held at 0.
//
// Ports
//   clk          in   system clock, all state on rising edge
//   reset        in   synchronous active-high reset
//   pcInc        in   advance PC by 1
//   pcBranchAbs  in   load branchAddr
//   pcBranchRel  in   add sign-extended branchOffset to PC
//   branchAddr   in   absolute target / call target
//   branchOffset in   signed relative offset
//   pcCall       in   call: push PC+1, jump to branchAddr
//   pcReturn     in   return: pop stack into PC
//   stall        in   freeze PC, stack and hold tracking
//   pcOut        out  current PC (program memory address)
//   branchTaken  out  last update was non-sequential
//   holding      out  PC unchanged on the last non-stalled cycle(s)
//   holdCount    out  consecutive held cycles, saturating
//   stackErr     out  sticky stack overflow/underflow flag
//-----------------------------------------------------------------------------
module program_counter #(
    parameter int PC_WIDTH    = 6,
    parameter int OFF_WIDTH   = 6,
    parameter int HOLD_WIDTH  = 8,
    parameter int STACK_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pcInc,
    input  logic                  pcBranchAbs,
    input  logic                  pcBranchRel,
    input  logic [PC_WIDTH-1:0]   branchAddr,
    input  logic [OFF_WIDTH-1:0]  branchOffset,
    input  logic                  pcCall,
    input  logic                  pcReturn,
    input  logic                  stall,
    output logic [PC_WIDTH-1:0]   pcOut,
    output logic                  branchTaken,
    output logic                  holding,
    output logic [HOLD_WIDTH-1:0] holdCount,
    output logic                  stackErr
);

    localparam logic [HOLD_WIDTH-1:0] HOLD_MAX = {HOLD_WIDTH{1'b1}};

    logic [PC_WIDTH-1:0]   pc_r;
    logic                  branchTaken_r;
    logic                  holding_r;
    logic [HOLD_WIDTH-1:0] holdCount_r;
    logic                  stackErr_r;

    logic [PC_WIDTH-1:0]   nextPc_s;
    logic                  nextBranch_s;
    logic                  nextStackErr_s;
    logic [PC_WIDTH-1:0]   pcPlusOne_s;
    logic [PC_WIDTH-1:0]   offExt_s;

    assign pcPlusOne_s = pc_r + PC_WIDTH'(1);
    // Size cast of a signed operand sign-extends the offset to PC width.
    assign offExt_s    = PC_WIDTH'(signed'(branchOffset));

`ifdef PC_RETURN_STACK_EN
    localparam int SP_W = $clog2(STACK_DEPTH + 1);
    localparam logic [SP_W-1:0] SP_FULL = SP_W'(STACK_DEPTH);

    logic [PC_WIDTH-1:0] stack_r [STACK_DEPTH];
    logic [SP_W-1:0]     sp_r;        // number of valid entries
    logic [PC_WIDTH-1:0] top_s;
    logic                doPush_s;
    logic                doPop_s;

    // Top-of-stack read; entry sp-1 is the most recent push.
    always_comb begin
        top_s = {PC_WIDTH{1'b0}};
        for (int i = 0; i < STACK_DEPTH; i++) begin
            if (sp_r == SP_W'(i + 1)) begin
                top_s = stack_r[i];
            end else begin
                top_s = top_s;
            end
        end
    end
`endif

    // Next-PC selection in priority order: stall > return > call > abs > rel > inc > hold.
    always_comb begin
        nextPc_s       = pc_r;
        nextBranch_s   = 1'b0;
        nextStackErr_s = stackErr_r;
`ifdef PC_RETURN_STACK_EN
        doPush_s       = 1'b0;
        doPop_s        = 1'b0;
`endif
        if (stall) begin
            nextPc_s = pc_r;
        end else if (pcReturn) begin
`ifdef PC_RETURN_STACK_EN
            nextBranch_s = 1'b1;
            if (sp_r == {SP_W{1'b0}}) begin
                // Underflow: fall through to the next instruction.
                nextPc_s       = pcPlusOne_s;
                nextStackErr_s = 1'b1;
            end else begin
                nextPc_s = top_s;
                doPop_s  = 1'b1;
            end
`else
            nextPc_s = pcPlusOne_s;
`endif
        end else if (pcCall) begin
            nextPc_s     = branchAddr;
            nextBranch_s = 1'b1;
`ifdef PC_RETURN_STACK_EN
            if (sp_r == SP_FULL) begin
                // Overflow: jump anyway, return address is lost.
                nextStackErr_s = 1'b1;
            end else begin
                doPush_s = 1'b1;
            end
`endif
        end else if (pcBranchAbs) begin
            nextPc_s     = branchAddr;
            nextBranch_s = 1'b1;
        end else if (pcBranchRel) begin
            nextPc_s     = pc_r + offExt_s;
            nextBranch_s = 1'b1;
        end else if (pcInc) begin
            nextPc_s = pcPlusOne_s;
        end else begin
            nextPc_s = pc_r;
        end
    end

    // PC, branch pulse, sticky error and hold tracking registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc_r          <= {PC_WIDTH{1'b0}};
            branchTaken_r <= 1'b0;
            holding_r     <= 1'b0;
            holdCount_r   <= {HOLD_WIDTH{1'b0}};
            stackErr_r    <= 1'b0;
        end else begin
            pc_r          <= nextPc_s;
            branchTaken_r <= nextBranch_s;
            stackErr_r    <= nextStackErr_s;
            if (stall) begin
                holding_r   <= holding_r;
                holdCount_r <= holdCount_r;
            end else if (nextPc_s == pc_r) begin
                // Any update that leaves the PC in place (incl. self-branches) is a hold.
                holding_r <= 1'b1;
                if (holdCount_r != HOLD_MAX) begin
                    holdCount_r <= holdCount_r + HOLD_WIDTH'(1);
                end else begin
                    holdCount_r <= holdCount_r;
                end
            end else begin
                holding_r   <= 1'b0;
                holdCount_r <= {HOLD_WIDTH{1'b0}};
            end
        end
    end

`ifdef PC_RETURN_STACK_EN
    // Return-address LIFO storage and pointer.
    always_ff @(posedge clk) begin
        if (reset) begin
            sp_r <= {SP_W{1'b0}};
            for (int i = 0; i < STACK_DEPTH; i++) begin
                stack_r[i] <= {PC_WIDTH{1'b0}};
            end
        end else if (doPush_s) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                if (sp_r == SP_W'(i)) begin
                    stack_r[i] <= pcPlusOne_s;
                end else begin
                    stack_r[i] <= stack_r[i];
                end
            end
            sp_r <= sp_r + SP_W'(1);
        end else if (doPop_s) begin
            sp_r <= sp_r - SP_W'(1);
        end else begin
            sp_r <= sp_r;
        end
    end
`endif

    assign pcOut       = pc_r;
    assign branchTaken = branchTaken_r;
    assign holding     = holding_r;
    assign holdCount   = holdCount_r;
    assign stackErr    = stackErr_r;

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

    localparam int PW = 6;
    localparam int OW = 6;
    localparam int HW = 8;
    localparam int SD = 4;
    localparam int PC_MOD = 64;
    localparam int HOLD_SAT = 255;

    logic          clk = 1'b0;
    logic          reset, pcInc, pcBranchAbs, pcBranchRel, pcCall, pcReturn, stall;
    logic [PW-1:0] branchAddr;
    logic [OW-1:0] branchOffset;
    logic [PW-1:0] pcOut;
    logic          branchTaken, holding, stackErr;
    logic [HW-1:0] holdCount;

    int errors = 0;
    int checks = 0;
    bit checkEn = 1'b0;

    // Behavioural model state
    int mPc, mBt, mHolding, mHoldCnt, mErr;
    int mStack[$];

    always #5 clk = ~clk;

    program_counter #(
        .PC_WIDTH(PW), .OFF_WIDTH(OW), .HOLD_WIDTH(HW), .STACK_DEPTH(SD)
    ) dut (
        .clk(clk), .reset(reset), .pcInc(pcInc), .pcBranchAbs(pcBranchAbs),
        .pcBranchRel(pcBranchRel), .branchAddr(branchAddr), .branchOffset(branchOffset),
        .pcCall(pcCall), .pcReturn(pcReturn), .stall(stall), .pcOut(pcOut),
        .branchTaken(branchTaken), .holding(holding), .holdCount(holdCount),
        .stackErr(stackErr)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Model: next PC from the rules, with plain integer arithmetic and a queue stack.
    task automatic modelUpdate();
        int nxt;
        int bt;
        int off;
        if (reset) begin
            mPc = 0; mBt = 0; mHolding = 0; mHoldCnt = 0; mErr = 0;
            mStack.delete();
        end else if (stall) begin
            mBt = 0;
        end else begin
            nxt = mPc;
            bt  = 0;
            off = int'(branchOffset);
            if (off >= PC_MOD / 2) off = off - PC_MOD;
            if (pcReturn) begin
`ifdef PC_RETURN_STACK_EN
                bt = 1;
                if (mStack.size() == 0) begin
                    nxt  = (mPc + 1) % PC_MOD;
                    mErr = 1;
                end else begin
                    nxt = mStack.pop_back();
                end
`else
                nxt = (mPc + 1) % PC_MOD;
`endif
            end else if (pcCall) begin
                nxt = int'(branchAddr);
                bt  = 1;
`ifdef PC_RETURN_STACK_EN
                if (mStack.size() == SD) mErr = 1;
                else mStack.push_back((mPc + 1) % PC_MOD);
`endif
            end else if (pcBranchAbs) begin
                nxt = int'(branchAddr);
                bt  = 1;
            end else if (pcBranchRel) begin
                nxt = (((mPc + off) % PC_MOD) + PC_MOD) % PC_MOD;
                bt  = 1;
            end else if (pcInc) begin
                nxt = (mPc + 1) % PC_MOD;
            end
            if (nxt == mPc) begin
                mHolding = 1;
                if (mHoldCnt < HOLD_SAT) mHoldCnt++;
            end else begin
                mHolding = 0;
                mHoldCnt = 0;
            end
            mPc = nxt;
            mBt = bt;
        end
    endtask

    // Compare process: every cycle, all outputs against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            chk("pcOut", int'(pcOut), mPc);
            chk("branchTaken", int'(branchTaken), mBt);
            chk("holding", int'(holding), mHolding);
            chk("holdCount", int'(holdCount), mHoldCnt);
            chk("stackErr", int'(stackErr), mErr);
        end
    end

    task automatic idle();
        reset = 1'b0; pcInc = 1'b0; pcBranchAbs = 1'b0; pcBranchRel = 1'b0;
        pcCall = 1'b0; pcReturn = 1'b0; stall = 1'b0;
        branchAddr = 6'd0; branchOffset = 6'd0;
    endtask

    task automatic cyc();
        @(posedge clk);
        modelUpdate();
        @(negedge clk);
    endtask

    task automatic absTo(input int a);
        idle(); pcBranchAbs = 1'b1; branchAddr = PW'(a); cyc();
    endtask

    initial begin
        idle();
        // 1. reset, then 70 increments with wrap
        reset = 1'b1;
        cyc();
        checkEn = 1'b1;
        cyc();
        chk("reset_pc", int'(pcOut), 0);
        chk("reset_hold", int'(holdCount), 0);
        idle(); pcInc = 1'b1;
        for (int i = 0; i < 70; i++) begin
            cyc();
            if (i == 63) chk("inc_wrap", int'(pcOut), 0);
        end
        chk("inc_70", int'(pcOut), 6);

        // 2. relative branches
        absTo(10);
        idle(); pcBranchRel = 1'b1; branchOffset = 6'h3D; cyc();   // -3
        chk("rel_neg", int'(pcOut), 7);
        chk("rel_bt", int'(branchTaken), 1);
        idle(); cyc();
        chk("rel_bt_clear", int'(branchTaken), 0);
        absTo(62);
        idle(); pcBranchRel = 1'b1; branchOffset = 6'd5; cyc();
        chk("rel_wrap", int'(pcOut), 3);

        // 3. WAIT loop with saturation
        absTo(20);
        idle();
        cyc();
        chk("hold_first", int'(holdCount), 1);
        chk("hold_flag", int'(holding), 1);
        for (int i = 1; i < 300; i++) cyc();
        chk("hold_sat", int'(holdCount), 255);
        pcInc = 1'b1; cyc();
        chk("hold_exit_pc", int'(pcOut), 21);
        chk("hold_exit_cnt", int'(holdCount), 0);

        // 4. abs beats rel; stall freezes
        absTo(5);
        idle(); pcBranchAbs = 1'b1; pcBranchRel = 1'b1; branchAddr = 6'd40; branchOffset = 6'd1; cyc();
        chk("abs_wins", int'(pcOut), 40);
        idle(); stall = 1'b1; pcInc = 1'b1; cyc();
        chk("stall_pc", int'(pcOut), 40);
        chk("stall_bt", int'(branchTaken), 0);
        idle(); pcBranchRel = 1'b1; branchOffset = 6'd0; cyc();
        chk("self_loop_hold", int'(holding), 1);

`ifdef PC_RETURN_STACK_EN
        // 5. call / return with overflow and underflow
        idle(); reset = 1'b1; cyc();
        absTo(3);
        idle(); pcCall = 1'b1; branchAddr = 6'd30; cyc();
        absTo(31);
        idle(); pcCall = 1'b1; branchAddr = 6'd50; cyc();
        idle(); pcReturn = 1'b1; cyc();
        chk("ret_1", int'(pcOut), 32);
        cyc();
        chk("ret_2", int'(pcOut), 4);
        idle(); pcCall = 1'b1; branchAddr = 6'd10;
        for (int i = 0; i < 5; i++) cyc();
        chk("ovf_err", int'(stackErr), 1);
        chk("ovf_pc", int'(pcOut), 10);
        idle(); pcReturn = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        chk("pop_last", int'(pcOut), 5);
        cyc();
        chk("underflow_pc", int'(pcOut), 6);
`else
        // 6. call/return degrade to abs/inc; reset mid-sequence
        idle(); pcCall = 1'b1; branchAddr = 6'd12; cyc();
        chk("call_pc", int'(pcOut), 12);
        chk("call_bt", int'(branchTaken), 1);
        idle(); pcReturn = 1'b1; cyc();
        chk("ret_pc", int'(pcOut), 13);
        chk("ret_err", int'(stackErr), 0);
        idle(); pcCall = 1'b1; branchAddr = 6'd33; reset = 1'b1; cyc();
        chk("midreset_pc", int'(pcOut), 0);
        chk("midreset_bt", int'(branchTaken), 0);
`endif

        // Randomized phase
        for (int i = 0; i < 3000; i++) begin
            idle();
            reset        = ($urandom_range(0, 99) < 2);
            stall        = ($urandom_range(0, 9) == 0);
            pcReturn     = ($urandom_range(0, 7) == 0);
            pcCall       = ($urandom_range(0, 7) == 0);
            pcBranchAbs  = ($urandom_range(0, 5) == 0);
            pcBranchRel  = ($urandom_range(0, 4) == 0);
            pcInc        = ($urandom_range(0, 1) == 0);
            branchAddr   = PW'($urandom_range(0, 63));
            branchOffset = OW'($urandom_range(0, 63));
            if ($urandom_range(0, 3) == 0) begin
                // bias toward WAIT loops
                pcReturn = 1'b0; pcCall = 1'b0; pcBranchAbs = 1'b0;
                pcBranchRel = 1'b0; pcInc = 1'b0;
            end
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
